// File: rtl/n64_joybus_rx.sv
// n64_joybus_rx: Joybus (N64) line receiver with a programmable frame length.
// The line is pulse-width coded and sent MSB first. The low time of each pulse encodes one
// data bit: 1 us low is a '1' and 3 us low is a '0'. A 1 us or 2 us low pulse after the
// last data bit is the stop bit.
// Optional feature macro: N64_RX_GLITCH_FILTER_EN adds a 3-sample majority filter after the
// synchroniser. It adds 2 cycles of latency and removes 1-cycle line pulses.
// Handshake: start is a 1-cycle request that is taken only while busy is low. busy stays high
// from the cycle after the accepted start until the cycle in which done or err pulses. A start
// in that same cycle is taken as a new frame.
// The FSM state is held in the 'state' variable, which checkers can bind to.
module n64_joybus_rx #(
    parameter int CLK_MHZ      = 50,
    parameter int MAX_BITS     = 264,
    parameter int HIGH_TMO_US  = 8,
    parameter int START_TMO_US = 0
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_BITS+1)-1:0] expected_bits,
    input  logic                          n64d,
    output logic                          busy,
    output logic [MAX_BITS-1:0]           data,
    output logic [$clog2(MAX_BITS+1)-1:0] bit_count,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int Q         = CLK_MHZ;
    localparam int BW        = $clog2(MAX_BITS + 1);
    localparam int STUCK_LIM = 5 * Q;
    localparam int HIGH_LIM  = HIGH_TMO_US * Q;
    localparam int START_LIM = START_TMO_US * Q;
    localparam int MAX_A     = (STUCK_LIM > HIGH_LIM) ? STUCK_LIM : HIGH_LIM;
    localparam int MAX_LIM   = (MAX_A > START_LIM) ? MAX_A : START_LIM;
    localparam int CW        = $clog2(MAX_LIM + 2);

    // Low-time window bounds, each window is (lo, hi]
    localparam logic [CW-1:0] W1_LO   = CW'(Q / 2);
    localparam logic [CW-1:0] W1_HI   = CW'((3 * Q) / 2);
    localparam logic [CW-1:0] W2_HI   = CW'((5 * Q) / 2);
    localparam logic [CW-1:0] W3_HI   = CW'((7 * Q) / 2);
    localparam logic [CW-1:0] STUCK_C = CW'(STUCK_LIM);
    localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_LIM);
    localparam logic [CW-1:0] START_C = CW'(START_LIM);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [BW-1:0] MAX_B   = BW'(MAX_BITS);
    localparam logic [BW-1:0] IDX_TOP = BW'(MAX_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_MEAS_LOW
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_BAD_PULSE,
        ERR_TIMEOUT,
        ERR_LENGTH
    } err_t;

    state_t                state, state_n;
    err_t                  code_q, code_n;
    logic [CW-1:0]         lc_q, lc_n, lc_inc;
    logic [CW-1:0]         hc_q, hc_n, hc_inc;
    logic [BW-1:0]         bc_q, bc_n;
    logic [BW-1:0]         exp_q, exp_n;
    logic [MAX_BITS-1:0]   data_q, data_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic                  sync1, sync2;
    logic                  ln;
    logic                  in_w1, in_w2, in_w3;

    // Two-flop synchroniser; both flops idle high like the line
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= n64d;
            sync2 <= sync1;
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    logic flt_d1, flt_d2, flt_q;

    // Majority of three consecutive samples, so a single-cycle pulse never reaches the FSM
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            flt_d1 <= 1'b1;
            flt_d2 <= 1'b1;
            flt_q  <= 1'b1;
        end else begin
            flt_d1 <= sync2;
            flt_d2 <= flt_d1;
            flt_q  <= (sync2 & flt_d1) | (sync2 & flt_d2) | (flt_d1 & flt_d2);
        end
    end

    assign ln = flt_q;
`else
    assign ln = sync2;
`endif

    assign in_w1  = (lc_q > W1_LO) && (lc_q <= W1_HI);
    assign in_w2  = (lc_q > W1_HI) && (lc_q <= W2_HI);
    assign in_w3  = (lc_q > W2_HI) && (lc_q <= W3_HI);
    assign lc_inc = (lc_q == CNT_MAX) ? lc_q : lc_q + 1'b1;
    assign hc_inc = (hc_q == CNT_MAX) ? hc_q : hc_q + 1'b1;

    // Next-state, counters, bit capture and result pulses
    always_comb begin
        state_n = state;
        code_n  = code_q;
        lc_n    = lc_q;
        hc_n    = hc_q;
        bc_n    = bc_q;
        exp_n   = exp_q;
        data_n  = data_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WAIT_LOW;
                    data_n  = '0;
                    bc_n    = '0;
                    code_n  = ERR_NONE;
                    lc_n    = '0;
                    hc_n    = '0;
                    exp_n   = (expected_bits > MAX_B) ? MAX_B : expected_bits;
                end
            end
            S_WAIT_LOW: begin
                if (!ln) begin
                    state_n = S_MEAS_LOW;
                    lc_n    = CW'(1);
                end else if ((bc_q != '0) && (hc_q > HIGH_C)) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end else if ((bc_q == '0) && (START_TMO_US != 0) && (hc_q > START_C)) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end else begin
                    hc_n = hc_inc;
                end
            end
            S_MEAS_LOW: begin
                if (!ln) begin
                    // lc_inc counts the current low sample, so the abort lands on sample 5Q+1
                    if (lc_inc > STUCK_C) begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                        code_n  = ERR_TIMEOUT;
                    end else begin
                        lc_n = lc_inc;
                    end
                end else begin
                    hc_n = '0;
                    if ((in_w1 || in_w3) && (bc_q < exp_q)) begin
                        data_n[IDX_TOP - bc_q] = in_w1;
                        bc_n    = bc_q + 1'b1;
                        state_n = S_WAIT_LOW;
                    end else if ((in_w1 || in_w2) && (bc_q == exp_q)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (in_w2 || in_w3) begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                        code_n  = ERR_LENGTH;
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                        code_n  = ERR_BAD_PULSE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            code_q <= ERR_NONE;
            lc_q   <= '0;
            hc_q   <= '0;
            bc_q   <= '0;
            exp_q  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            code_q <= code_n;
            lc_q   <= lc_n;
            hc_q   <= hc_n;
            bc_q   <= bc_n;
            exp_q  <= exp_n;
            data_q <= data_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign busy      = (state != S_IDLE);
    assign data      = data_q;
    assign bit_count = bc_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_n64_joybus_rx.sv
// Testbench for n64_joybus_rx: directed protocol scenarios plus randomized frames
// checked against a pulse-list reference model.
module tb_n64_joybus_rx;

    localparam int Q        = 50;
    localparam int MAX_BITS = 264;
    localparam int BW       = $clog2(MAX_BITS + 1);
`ifdef N64_RX_GLITCH_FILTER_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic                sys_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [BW-1:0]       expected_bits = '0;
    logic                n64d = 1'b1;
    logic                busy;
    logic [MAX_BITS-1:0] data;
    logic [BW-1:0]       bit_count;
    logic                done;
    logic                err;
    logic [1:0]          err_code;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboard: expected data word per randomized frame
    logic [MAX_BITS-1:0] exp_q[$];
    int                  lows[$];

    // Event monitor state
    int                  n_done = 0;
    int                  n_err = 0;
    logic [MAX_BITS-1:0] cap_data = '0;
    logic [BW-1:0]       cap_bc = '0;
    logic [1:0]          cap_code = '0;

    n64_joybus_rx #(
        .CLK_MHZ(Q),
        .MAX_BITS(MAX_BITS),
        .HIGH_TMO_US(8),
        .START_TMO_US(0)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .start(start),
        .expected_bits(expected_bits),
        .n64d(n64d),
        .busy(busy),
        .data(data),
        .bit_count(bit_count),
        .done(done),
        .err(err),
        .err_code(err_code)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    // Record every done/err pulse with the outputs seen in that cycle
    always @(negedge sys_clk) begin
        if (done) begin
            n_done   = n_done + 1;
            cap_data = data;
            cap_bc   = bit_count;
            cap_code = err_code;
        end
        if (err) begin
            n_err    = n_err + 1;
            cap_data = data;
            cap_bc   = bit_count;
            cap_code = err_code;
        end
    end

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic line_low(input int n);
        n64d = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic line_high(input int n);
        n64d = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            line_low(Q);
            line_high(3 * Q);
        end else begin
            line_low(3 * Q);
            line_high(Q);
        end
    endtask

    task automatic pulse_start(input int e);
        expected_bits = BW'(e);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_event(input int ev0, input int budget, output bit seen);
        int cnt;
        cnt = 0;
        seen = 1'b0;
        while (cnt < budget && !seen) begin
            @(negedge sys_clk);
            cnt++;
            if (n_done + n_err > ev0) seen = 1'b1;
        end
    endtask

    // Reference model: classify each low time of the pulse list by the window rules.
    // m_code: 0 good frame, 1 bad pulse, 2 timeout, 3 length.
    function automatic void model(input int e_in, output logic [MAX_BITS-1:0] m_data,
                                  output int m_bc, output int m_code);
        int e, i, len, w;
        bit fin;
        e = (e_in > MAX_BITS) ? MAX_BITS : e_in;
        m_data = '0;
        m_bc = 0;
        m_code = 0;
        fin = 1'b0;
        i = 0;
        while (!fin && i < lows.size()) begin
            len = lows[i];
            i++;
            if (len > 5 * Q) begin
                m_code = 2;
                fin = 1'b1;
            end else begin
                if (len > Q / 2 && len <= (3 * Q) / 2) w = 1;
                else if (len > (3 * Q) / 2 && len <= (5 * Q) / 2) w = 2;
                else if (len > (5 * Q) / 2 && len <= (7 * Q) / 2) w = 3;
                else w = 0;
                if (w == 0) begin
                    m_code = 1;
                    fin = 1'b1;
                end else if (m_bc == e) begin
                    m_code = (w == 3) ? 3 : 0;
                    fin = 1'b1;
                end else if (w == 2) begin
                    m_code = 3;
                    fin = 1'b1;
                end else begin
                    m_data[MAX_BITS - 1 - m_bc] = (w == 1);
                    m_bc++;
                end
            end
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", data); end
        tests_run++;
        if (bit_count !== '0) begin tests_failed++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
        tests_run++;
        if (done !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done, err); end
        tests_run++;
        if (err_code !== 2'd0) begin tests_failed++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    endtask

    task automatic test_controller;
        logic [31:0] word;
        int d0, e0;
        bit seen;
        word = 32'h8000_0001;
        d0 = n_done; e0 = n_err;
        pulse_start(32);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ctrl_busy: got %b want 1", busy); end
        line_high(20);
        for (int i = 31; i >= 0; i--) send_bit(word[i]);
        line_low(2 * Q);
        n64d = 1'b1;
        wait_event(d0 + e0, 20, seen);
        tests_run++;
        if (!seen || n_done !== d0 + 1 || n_err !== e0) begin tests_failed++; $display("FAIL ctrl_done: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0); end
        tests_run++;
        if (cap_data[MAX_BITS-1 -: 32] !== word) begin tests_failed++; $display("FAIL ctrl_data: got %h want %h", cap_data[MAX_BITS-1 -: 32], word); end
        tests_run++;
        if (cap_data[MAX_BITS-33:0] !== '0) begin tests_failed++; $display("FAIL ctrl_low_bits: got nonzero want 0"); end
        tests_run++;
        if (cap_bc !== BW'(32) || cap_code !== 2'd0) begin tests_failed++; $display("FAIL ctrl_count: got bc=%0d code=%0d want 32 0", cap_bc, cap_code); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL ctrl_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_console;
        logic [7:0] cmd;
        int d0, e0;
        bit seen;
        cmd = 8'h01;
        d0 = n_done; e0 = n_err;
        pulse_start(8);
        line_high(15);
        for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
        line_low(Q);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
        tests_run++;
        if (!seen || n_done !== d0 + 1 || n_err !== e0) begin tests_failed++; $display("FAIL console_done: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0); end
        tests_run++;
        if (cap_data[MAX_BITS-1 -: 8] !== cmd || cap_bc !== BW'(8)) begin tests_failed++; $display("FAIL console_data: got %h bc=%0d want %h 8", cap_data[MAX_BITS-1 -: 8], cap_bc, cmd); end
    endtask

    task automatic test_zero_len;
        int d0, e0;
        bit seen;
        d0 = n_done; e0 = n_err;
        pulse_start(0);
        line_high(10);
        line_low(2 * Q);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
        tests_run++;
        if (!seen || n_done !== d0 + 1 || cap_bc !== '0 || cap_data !== '0) begin tests_failed++; $display("FAIL zero_len: got done=%0d bc=%0d want 1 0", n_done - d0, cap_bc); end
    endtask

    task automatic test_short_frame;
        logic [15:0] bits;
        int d0, e0;
        bit seen;
        bits = 16'($urandom);
        d0 = n_done; e0 = n_err;
        pulse_start(32);
        line_high(10);
        for (int i = 15; i >= 0; i--) send_bit(bits[i]);
        line_low(2 * Q);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
        tests_run++;
        if (!seen || n_err !== e0 + 1 || n_done !== d0) begin tests_failed++; $display("FAIL short_err: got done=%0d err=%0d want 0 1", n_done - d0, n_err - e0); end
        tests_run++;
        if (cap_code !== 2'd3 || cap_bc !== BW'(16)) begin tests_failed++; $display("FAIL short_code: got code=%0d bc=%0d want 3 16", cap_code, cap_bc); end
        tests_run++;
        if (data[MAX_BITS-1 -: 16] !== bits || bit_count !== BW'(16) || err_code !== 2'd3) begin tests_failed++; $display("FAIL short_hold: got %h bc=%0d want %h 16", data[MAX_BITS-1 -: 16], bit_count, bits); end
    endtask

    task automatic test_timeout;
        int e0, cnt;
        bit seen;
        // stuck low
        e0 = n_err;
        pulse_start(8);
        line_high(10);
        n64d = 1'b0;
        cnt = 0;
        while (!err && cnt < 400) begin
            @(negedge sys_clk);
            cnt++;
        end
        tests_run++;
        if (cnt !== 251 + 2 + LAT_EXTRA) begin tests_failed++; $display("FAIL stuck_latency: got %0d cycles want %0d", cnt, 251 + 2 + LAT_EXTRA); end
        tests_run++;
        if (err_code !== 2'd2 || busy !== 1'b0) begin tests_failed++; $display("FAIL stuck_code: got code=%0d busy=%b want 2 0", err_code, busy); end
        line_high(20);
        // high too long after bit 3
        e0 = n_err;
        pulse_start(8);
        line_high(10);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        line_high(9 * Q);
        wait_event(n_done + e0, 10, seen);
        tests_run++;
        if (!seen || n_err !== e0 + 1 || cap_code !== 2'd2 || cap_bc !== BW'(3)) begin tests_failed++; $display("FAIL high_timeout: got err=%0d code=%0d bc=%0d want 1 2 3", n_err - e0, cap_code, cap_bc); end
    endtask

    task automatic test_bad_pulse;
        int d0, e0;
        bit seen;
        d0 = n_done; e0 = n_err;
        pulse_start(8);
        line_high(10);
        line_low(Q / 5);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
        tests_run++;
        if (!seen || n_err !== e0 + 1 || cap_code !== 2'd1 || cap_bc !== '0) begin tests_failed++; $display("FAIL bad_pulse: got err=%0d code=%0d bc=%0d want 1 1 0", n_err - e0, cap_code, cap_bc); end
    endtask

    task automatic test_glitch;
        logic [7:0] byte_v;
        int d0, e0;
        bit seen;
        byte_v = 8'hC6;
        d0 = n_done; e0 = n_err;
        pulse_start(8);
        line_high(10);
        for (int i = 7; i >= 5; i--) send_bit(byte_v[i]);
        line_high(20);
        line_low(1);
        line_high(30);
        for (int i = 4; i >= 0; i--) send_bit(byte_v[i]);
        line_low(Q);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
`ifdef N64_RX_GLITCH_FILTER_EN
        tests_run++;
        if (!seen || n_done !== d0 + 1 || n_err !== e0 || cap_data[MAX_BITS-1 -: 8] !== byte_v) begin tests_failed++; $display("FAIL glitch_filtered: got done=%0d err=%0d data=%h want 1 0 %h", n_done - d0, n_err - e0, cap_data[MAX_BITS-1 -: 8], byte_v); end
`else
        tests_run++;
        if (!seen || n_err !== e0 + 1 || cap_code !== 2'd1 || cap_bc !== BW'(3)) begin tests_failed++; $display("FAIL glitch_unfiltered: got err=%0d code=%0d bc=%0d want 1 1 3", n_err - e0, cap_code, cap_bc); end
`endif
    endtask

    task automatic test_reset_mid;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        pulse_start(8);
        line_high(10);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        line_low(40);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
        tests_run++;
        if (data !== '0 || bit_count !== '0 || err_code !== 2'd0) begin tests_failed++; $display("FAIL rst_mid_regs: got bc=%0d code=%0d want 0 0", bit_count, err_code); end
        n64d = 1'b1;
        rst_n = 1'b1;
        line_high(20);
        tests_run++;
        if (n_done !== d0 || n_err !== e0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_silent: got done=%0d err=%0d busy=%b want 0 0 0", n_done - d0, n_err - e0, busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]          b1;
        logic [3:0]          b2;
        logic [MAX_BITS-1:0] want;
        int d0, e0, cnt;
        bit seen;
        b1 = 8'hA5;
        b2 = 4'b1011;
        d0 = n_done; e0 = n_err;
        pulse_start(8);
        line_high(10);
        send_bit(b1[7]);
        send_bit(b1[6]);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_mid: got %b want 1", busy); end
        pulse_start(3);
        for (int i = 5; i >= 0; i--) send_bit(b1[i]);
        line_low(Q);
        n64d = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge sys_clk);
            cnt++;
        end
        tests_run++;
        if (done !== 1'b1 || data[MAX_BITS-1 -: 8] !== b1 || bit_count !== BW'(8)) begin tests_failed++; $display("FAIL b2b_first: got done=%b data=%h bc=%0d want 1 %h 8", done, data[MAX_BITS-1 -: 8], bit_count, b1); end
        // start inside the done cycle
        pulse_start(4);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
        d0 = n_done; e0 = n_err;
        line_high(10);
        for (int i = 3; i >= 0; i--) send_bit(b2[i]);
        line_low(2 * Q);
        line_high(10);
        wait_event(d0 + e0, 10, seen);
        want = '0;
        want[MAX_BITS-1 -: 4] = b2;
        tests_run++;
        if (!seen || n_done !== d0 + 1 || cap_data !== want || cap_bc !== BW'(4)) begin tests_failed++; $display("FAIL b2b_second: got done=%0d data=%h bc=%0d want 1 %h 4", n_done - d0, cap_data[MAX_BITS-1 -: 8], cap_bc, want[MAX_BITS-1 -: 8]); end
    endtask

    task automatic test_random;
        for (int f = 0; f < 10; f++) begin
            int e, kind, nb, d0, e0, m_bc, m_code;
            logic [MAX_BITS-1:0] m_data, want;
            bit seen;
            e = $urandom_range(0, 12);
            kind = $urandom_range(0, 4);
            lows.delete();
            nb = (kind == 0 || kind == 2) ? e : $urandom_range(0, e);
            for (int i = 0; i < nb; i++)
                lows.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(30, 70) : $urandom_range(130, 170));
            case (kind)
                0: lows.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(30, 70) : $urandom_range(80, 120));
                1: lows.push_back($urandom_range(80, 120));
                2: lows.push_back($urandom_range(130, 170));
                3: lows.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : $urandom_range(180, 240));
                default: lows.push_back(300);
            endcase
            model(e, m_data, m_bc, m_code);
            exp_q.push_back(m_data);
            d0 = n_done; e0 = n_err;
            pulse_start(e);
            line_high($urandom_range(5, 60));
            foreach (lows[i]) begin
                line_low(lows[i]);
                line_high($urandom_range(20, 80));
            end
            wait_event(d0 + e0, 10, seen);
            want = exp_q.pop_front();
            tests_run++;
            if (m_code == 0) begin
                if (!seen || n_done !== d0 + 1 || n_err !== e0 || cap_code !== 2'd0) begin tests_failed++; $display("FAIL rand_outcome[%0d]: got done=%0d err=%0d code=%0d want done", f, n_done - d0, n_err - e0, cap_code); end
            end else begin
                if (!seen || n_err !== e0 + 1 || n_done !== d0 || cap_code !== 2'(m_code)) begin tests_failed++; $display("FAIL rand_outcome[%0d]: got done=%0d err=%0d code=%0d want err code %0d", f, n_done - d0, n_err - e0, cap_code, m_code); end
            end
            tests_run++;
            if (cap_bc !== BW'(m_bc)) begin tests_failed++; $display("FAIL rand_bit_count[%0d]: got %0d want %0d", f, cap_bc, m_bc); end
            tests_run++;
            if (cap_data !== want) begin tests_failed++; $display("FAIL rand_data[%0d]: got %h want %h", f, cap_data[MAX_BITS-1 -: 16], want[MAX_BITS-1 -: 16]); end
        end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_controller();
        test_console();
        test_zero_len();
        test_short_frame();
        test_timeout();
        test_bad_pulse();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
